// File: rtl/trie_lookup_arbiter.sv
// trie_lookup_arbiter
// Round-robin front end that shares one fixed-latency trie lookup pipeline
// between NUM_REQ requesters. Each lookup that is issued gets a {vld, idx} tag.
// The tag travels in a shift line beside the trie pipeline, so every
// nexthop result can be steered back to the requester that issued it.
module trie_lookup_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PIPE_LATENCY = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_ip,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   hold,
    output logic [31:0]            trie_ip,
    input  logic [7:0]             trie_nexthop,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [7:0]             rsp_nexthop,
    output logic                   busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]         ptr;
    logic                  gnt;
    logic [PW-1:0]         gnt_idx;
    logic [PW-1:0]         cand;

    // The tag line is one entry longer than the trie latency because trie_ip
    // is itself a register. A result appears on trie_nexthop PIPE_LATENCY
    // cycles after trie_ip is loaded. At that point the tag sits at index
    // PIPE_LATENCY.
    logic [PIPE_LATENCY:0] tag_vld;
    logic [PW-1:0]         tag_idx [0:PIPE_LATENCY];

    // Pick the first valid requester at or above ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt     = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PW'((int'(ptr) + i) % NUM_REQ);
            if (!gnt && req_valid[cand]) begin
                gnt     = 1'b1;
                gnt_idx = cand;
            end
        end
        if (rst || hold) begin
            gnt = 1'b0;
        end
    end

    assign req_ready = gnt ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign busy      = |tag_vld;

    // Advance the pointer on each grant and issue the IP. A cycle with no
    // grant issues a zero bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            trie_ip <= '0;
        end else begin
            trie_ip <= gnt ? req_ip[32*gnt_idx +: 32] : 32'd0;
            if (gnt) begin
                ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Shift the tag valid bits. Reset clears them, which discards any
    // in-flight lookups.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
        end else begin
            tag_vld <= {tag_vld[PIPE_LATENCY-1:0], gnt};
        end
    end

    // Shift the tag indices. They only matter when the matching vld bit is set.
    always_ff @(posedge clk) begin
        tag_idx[0] <= gnt_idx;
        for (int s = 1; s <= PIPE_LATENCY; s++) begin
            tag_idx[s] <= tag_idx[s-1];
        end
    end

    // Return the trie result to the requester named by the head tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid   <= '0;
            rsp_nexthop <= '0;
        end else if (tag_vld[PIPE_LATENCY]) begin
            rsp_valid   <= NUM_REQ'(1) << tag_idx[PIPE_LATENCY];
            rsp_nexthop <= trie_nexthop;
        end else begin
            rsp_valid   <= '0;
        end
    end

endmodule

// File: tb/tb_trie_lookup_arbiter.sv
// Bench for trie_lookup_arbiter.
// A stand-in trie returns ip[31:24] PIPE_LATENCY cycles after trie_ip.
// The reference model keeps the round-robin pointer as an integer and holds
// each accepted lookup in a queue, with the edge at which its response is due.
module tb_trie_lookup_arbiter;

    localparam int N = 4;
    localparam int L = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              hold = 1'b0;
    logic [N-1:0]      req_valid;
    logic [32*N-1:0]   req_ip;
    logic [N-1:0]      req_ready;
    logic [31:0]       trie_ip;
    logic [7:0]        trie_nexthop;
    logic [N-1:0]      rsp_valid;
    logic [7:0]        rsp_nexthop;
    logic              busy;

    always #5 clk = ~clk;

    trie_lookup_arbiter #(.NUM_REQ(N), .PIPE_LATENCY(L)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ip       (req_ip),
        .req_ready    (req_ready),
        .hold         (hold),
        .trie_ip      (trie_ip),
        .trie_nexthop (trie_nexthop),
        .rsp_valid    (rsp_valid),
        .rsp_nexthop  (rsp_nexthop),
        .busy         (busy)
    );

    // Trie stand-in: an L-stage delay of trie_ip. It is never reset.
    logic [31:0] tpipe [0:L-1];
    always @(posedge clk) begin
        tpipe[0] <= trie_ip;
        for (int i = 1; i < L; i++) tpipe[i] <= tpipe[i-1];
    end
    assign trie_nexthop = tpipe[L-1][31:24];

    typedef struct {
        int         due;
        int         idx;
        logic [7:0] nh;
    } inflight_t;

    inflight_t   q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mptr = 0;
    logic [31:0] exp_tip = 0;
    logic [31:0] exp_rv = 0;
    logic [31:0] exp_nh = 0;
    logic [31:0] exp_busy = 0;
    logic [31:0] exp_rdy;
    logic        pend [N];
    logic [31:0] rip  [N];
    int          grant_hist[$];
    int          g;
    logic        mode_all;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0;
            rip[k]  = 32'd0;
        end
        req_valid = '0;
        req_ip    = '0;
        @(posedge clk);
        @(posedge clk);
        #1;

        for (int t = 0; t < 400; t++) begin
            rst      = (t == 150);
            hold     = (t >= 60 && t < 80);
            mode_all = (t < 100);
            for (int k = 0; k < N; k++) begin
                if (!pend[k]) begin
                    if (mode_all) begin
                        pend[k] = 1'b1;
                        rip[k]  = 32'(k + 1) << 28;
                    end else if ($urandom_range(0, 2) == 0) begin
                        pend[k] = 1'b1;
                        rip[k]  = $urandom;
                    end
                end
                req_valid[k]        = pend[k];
                req_ip[32*k +: 32]  = rip[k];
            end

            @(negedge clk);
            g = -1;
            if (!rst && !hold) begin
                for (int i = 0; i < N; i++) begin
                    if (g < 0 && pend[(mptr + i) % N]) g = (mptr + i) % N;
                end
            end
            exp_rdy = (g < 0) ? 32'd0 : (32'd1 << g);
            check("req_ready", 32'(req_ready), exp_rdy);
            check("trie_ip", trie_ip, exp_tip);
            check("rsp_valid", 32'(rsp_valid), exp_rv);
            check("rsp_nexthop", 32'(rsp_nexthop), exp_nh);
            check("busy", 32'(busy), exp_busy);

            @(posedge clk);
            cyc++;
            if (rst) begin
                q.delete();
                mptr     = 0;
                exp_tip  = 0;
                exp_rv   = 0;
                exp_nh   = 0;
            end else begin
                exp_tip = (g >= 0) ? rip[g] : 32'd0;
                if (g >= 0) begin
                    q.push_back('{due: cyc + L + 1, idx: g, nh: rip[g][31:24]});
                    mptr    = (g + 1) % N;
                    pend[g] = 1'b0;
                    if (t < 40) grant_hist.push_back(g);
                end
                exp_rv = 0;
                if (q.size() > 0 && q[0].due == cyc) begin
                    exp_rv = 32'd1 << q[0].idx;
                    exp_nh = 32'(q[0].nh);
                    void'(q.pop_front());
                end
            end
            exp_busy = (q.size() > 0) ? 32'd1 : 32'd0;
            #1;
        end

        // With all requesters continuously valid, grants rotate 0,1,2,3,...
        for (int i = 0; i < grant_hist.size(); i++) begin
            check("rotation", 32'(grant_hist[i]), 32'(i % N));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
